// File: rtl/uart_tx_buffer_if.sv
// uart_tx_buffer_if: cpu memory-bus write snoop plus the buffer-full stall back to the cpu
interface uart_tx_buffer_if;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic        io_buffer_full;
    modport master (output rdy_in, mem_a, mem_dout, mem_wr, input io_buffer_full);
    modport slave (input rdy_in, mem_a, mem_dout, mem_wr, output io_buffer_full);
endinterface

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: queues cpu char/stop writes in a FIFO and serializes them as 8N1 UART frames
module uart_tx_buffer #(
    parameter int FIFO_AW     = 4,
    parameter int FULL_MARGIN = 2,
    parameter int BAUD_DIV    = 868
) (
    input  logic            clk_in,
    input  logic            rst_in,
    uart_tx_buffer_if.slave bus,
    output logic            tx,
    output logic            tx_busy,
    output logic            program_done,
    output logic            overflow
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(BAUD_DIV - 1);
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] FULL_AT = (FIFO_AW + 1)'(DEPTH - FULL_MARGIN);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [BW-1:0]      baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tag_q, tag_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic               stop_q, stop_d;
    logic [FIFO_AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic [8:0]         mem_q [DEPTH];

    logic       io, is_stop, push_req, push_ok, pop, fifo_nz;
    logic [8:0] head;
    logic       unused_addr;

    assign unused_addr = ^{bus.mem_a[31:18], bus.mem_a[15:3]};
    assign io = bus.rdy_in & bus.mem_wr & (bus.mem_a[17:16] == 2'b11);
    assign is_stop = bus.mem_a[2:0] == 3'd4;
    assign push_req = io & ~stop_q & (is_stop | (bus.mem_a[2:0] == 3'd0 & bus.mem_dout != 8'h00));
    // a pop in the same cycle frees the slot, so a push at full still lands
    assign push_ok = push_req & ((cnt_q != DEPTH_C) | pop);
    assign fifo_nz = cnt_q != '0;
    assign head = mem_q[rd_q];

    assign cnt_d = cnt_q + {{FIFO_AW{1'b0}}, push_ok} - {{FIFO_AW{1'b0}}, pop};
    assign wr_d = wr_q + FIFO_AW'(push_ok);
    assign rd_d = rd_q + FIFO_AW'(pop);
    assign ovf_d = ovf_q | (push_req & ~push_ok);
    assign stop_d = stop_q | (io & is_stop);

    assign bus.io_buffer_full = cnt_q >= FULL_AT;
    assign tx = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
    assign tx_busy = (state_q != IDLE) | fifo_nz;
    assign program_done = done_q;
    assign overflow = ovf_q;

    always_comb begin
        state_d = state_q;
        bit_d = bit_q;
        shift_d = shift_q;
        tag_d = tag_q;
        done_d = done_q;
        pop = 1'b0;
        unique case (state_q)
            IDLE: if (fifo_nz & ~done_q) begin
                pop = 1'b1;
                state_d = START;
            end
            START: if (baud_q == '0) begin
                bit_d = '0;
                state_d = DATA;
            end
            DATA: if (baud_q == '0) begin
                shift_d = shift_q >> 1;
                bit_d = bit_q + 3'd1;
                state_d = bit_q == 3'd7 ? STOP : DATA;
            end
            STOP: if (baud_q == '0) begin
                if (tag_q) begin
                    done_d = 1'b1;
                    state_d = IDLE;
                end else if (fifo_nz) begin
                    pop = 1'b1;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
        baud_d = (pop | (baud_q == '0)) ? BAUD_MAX : baud_q - BW'(1);
        if (pop) {tag_d, shift_d} = head;
    end

    always_ff @(posedge clk_in)
        if (push_ok) mem_q[wr_q] <= {is_stop, is_stop ? 8'h00 : bus.mem_dout};

    always_ff @(posedge clk_in or negedge rst_in)
        if (!rst_in) begin
            state_q <= IDLE;
            baud_q <= '0;
            bit_q <= '0;
            shift_q <= '0;
            tag_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q <= 1'b0;
            stop_q <= 1'b0;
            rd_q <= '0;
            wr_q <= '0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q <= baud_d;
            bit_q <= bit_d;
            shift_q <= shift_d;
            tag_q <= tag_d;
            done_q <= done_d;
            ovf_q <= ovf_d;
            stop_q <= stop_d;
            rd_q <= rd_d;
            wr_q <= wr_d;
            cnt_q <= cnt_d;
        end
endmodule
